io_space_ctrl: RTL and testbench

// - Parametrised I/O register space for the CPU: NUM_PORTS GPIO ports, per-port pin-change interrupts, vectored IRQ.
// - Sits on the CPU's I/O bus (cs/we/oe/address/data); drives external pins; feeds irq/vector to the control unit.

---
 rtl/io_space_ctrl_if.sv | 15 +
 rtl/io_space_ctrl.sv | 74 +++++++
 tb/tb_io_space_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/io_space_ctrl_if.sv
// io_space_ctrl_if: CPU I/O bus control/handshake signals for the I/O register space.
interface io_space_ctrl_if #(
  parameter int ADDR_WIDTH   = 6,
  parameter int I_ADDR_WIDTH = 10
);
  logic                    cs;
  logic                    we;
  logic                    oe;
  logic [ADDR_WIDTH-1:0]   address;
  logic                    ack;
  logic                    irq;
  logic [I_ADDR_WIDTH-1:0] vector;
  modport master (output cs, we, oe, address, ack, input irq, vector);
  modport slave  (input cs, we, oe, address, ack, output irq, vector);
endinterface

// File: rtl/io_space_ctrl.sv
// io_space_ctrl: GPIO register space with pin-change interrupts and vectored irq, negedge-clocked.
// Optional PIN_TOGGLE_EN: writing PINk toggles PORTk bits instead of being ignored.
module io_space_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int I_ADDR_WIDTH = 10,
  parameter int NUM_PORTS    = 2,
  parameter logic [I_ADDR_WIDTH-1:0] IRQ_BASE = 10'h010
) (
  input  logic                              clk,
  input  logic                              reset,
  io_space_ctrl_if.slave                    bus,
  inout  wire  [DATA_WIDTH-1:0]             data,
  inout  wire  [NUM_PORTS*DATA_WIDTH-1:0]   pins
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_PCMSK = ADDR_WIDTH'('h30);
  localparam logic [ADDR_WIDTH-1:0] A_PCIFR = ADDR_WIDTH'('h38);
  localparam logic [ADDR_WIDTH-1:0] A_PCICR = ADDR_WIDTH'('h39);
  localparam logic [ADDR_WIDTH-1:0] A_SPL   = ADDR_WIDTH'('h3D);
  localparam logic [ADDR_WIDTH-1:0] A_SREG  = ADDR_WIDTH'('h3F);
  localparam logic [DATA_WIDTH-1:0] PMASK   = DATA_WIDTH'((1 << NUM_PORTS) - 1);
  logic [DATA_WIDTH-1:0]           mem [NREG];
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] sync1;
  logic [NUM_PORTS-1:0]            pend, hw_set, ack_clr, pin_wr;
  logic [2:0]                      sel;
  logic [DATA_WIDTH-1:0]           w1c, flags_nxt;
  always_comb begin
    pend   = '0;
    hw_set = '0;
    pin_wr = '0;
    sel    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pend[k]   = mem[A_PCIFR][k] & mem[A_PCICR][k];
      hw_set[k] = |((sync1[k*DATA_WIDTH +: DATA_WIDTH] ^ mem[ADDR_WIDTH'(3*k)]) & mem[A_PCMSK + ADDR_WIDTH'(k)]);
      pin_wr[k] = bus.cs && bus.we && bus.address == ADDR_WIDTH'(3*k);
    end
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (pend[k]) sel = 3'(k);
    ack_clr   = (bus.ack && |pend) ? NUM_PORTS'(1) << sel : '0;
    w1c       = (bus.cs && bus.we && bus.address == A_PCIFR) ? data : '0;
    // hardware set is OR-ed last so a simultaneous clear never loses an edge
    flags_nxt = ((mem[A_PCIFR] & ~w1c & ~DATA_WIDTH'(ack_clr)) | DATA_WIDTH'(hw_set)) & PMASK;
  end
  assign bus.irq    = mem[A_SREG][7] & |pend;
  assign bus.vector = IRQ_BASE + I_ADDR_WIDTH'(sel);
  assign data = (bus.cs && bus.oe && !bus.we) ? mem[rd_addr] : 'z;
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_bit
      assign pins[k*DATA_WIDTH + j] = mem[ADDR_WIDTH'(3*k+1)][j] ? mem[ADDR_WIDTH'(3*k+2)][j] : 1'bz;
    end
  end
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= (ADDR_WIDTH'(i) == A_SPL) ? DATA_WIDTH'('hBF) : '0;
      sync1   <= '0;
      rd_addr <= '0;
    end else begin
      sync1 <= pins;
      if (bus.cs && !bus.we) rd_addr <= bus.address;
      if (bus.cs && bus.we && pin_wr == '0)
        mem[bus.address] <= (bus.address == A_PCICR) ? data & PMASK : data;
      for (int k = 0; k < NUM_PORTS; k++) begin
        mem[ADDR_WIDTH'(3*k)] <= sync1[k*DATA_WIDTH +: DATA_WIDTH];
`ifdef PIN_TOGGLE_EN
        if (pin_wr[k]) mem[ADDR_WIDTH'(3*k+2)] <= mem[ADDR_WIDTH'(3*k+2)] ^ data;
`endif
      end
      mem[A_PCIFR] <= flags_nxt;
    end
  end
endmodule

// File: tb/tb_io_space_ctrl.sv
// tb_io_space_ctrl: vector table plus hand sequences for io_space_ctrl; pulled-up nets expose high-Z as 1.
module tb_io_space_ctrl;
  logic        clk = 0;
  logic        reset;
  logic        drv;
  logic [7:0]  dval;
  logic [15:0] ext_en, ext_val;
  tri1  [7:0]  data;
  tri1  [15:0] pins;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] dat;
    string      name;
  } vec_t;
  vec_t tbl[18];
  io_space_ctrl_if #(.ADDR_WIDTH(6), .I_ADDR_WIDTH(10)) bus ();
  io_space_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .I_ADDR_WIDTH(10), .NUM_PORTS(2), .IRQ_BASE(10'h010)) dut (
    .clk(clk), .reset(reset), .bus(bus), .data(data), .pins(pins)
  );
  assign data = drv ? dval : 'z;
  for (genvar g = 0; g < 16; g++) begin : g_ext
    assign pins[g] = ext_en[g] ? ext_val[g] : 1'bz;
  end
  always #5 clk = ~clk;
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    bus.cs = 1; bus.we = 1; bus.oe = 0; bus.address = a; dval = d; drv = 1;
    step();
    bus.cs = 0; bus.we = 0; drv = 0;
  endtask
  task automatic rd(input string nm, input logic [5:0] a, input logic [7:0] e);
    bus.cs = 1; bus.we = 0; bus.oe = 1; bus.address = a;
    exp_q.push_back(e);
    step();
    chk(nm, {8'h00, data}, {8'h00, exp_q.pop_front()});
    bus.cs = 0; bus.oe = 0;
  endtask
  initial begin
    tbl = '{
      '{1'b1, 6'h01, 8'h0F, "w_ddr0"},  '{1'b1, 6'h02, 8'hA5, "w_port0"},
      '{1'b0, 6'h01, 8'h0F, "ddr0"},    '{1'b0, 6'h02, 8'hA5, "port0"},
      '{1'b0, 6'h3D, 8'hBF, "spl"},     '{1'b0, 6'h3F, 8'h00, "sreg"},
      '{1'b0, 6'h05, 8'h00, "port1"},   '{1'b1, 6'h20, 8'h5A, "w_plain"},
      '{1'b0, 6'h20, 8'h5A, "plain"},   '{1'b1, 6'h39, 8'hFF, "w_pcicr"},
      '{1'b0, 6'h39, 8'h03, "pcicr_mask"}, '{1'b1, 6'h39, 8'h00, "w_pcicr0"},
      '{1'b1, 6'h37, 8'h77, "w_pcmsk_oor"}, '{1'b0, 6'h37, 8'h77, "pcmsk_oor"},
      '{1'b1, 6'h06, 8'h99, "w_port2_area"}, '{1'b0, 6'h06, 8'h99, "port2_area"},
      '{1'b1, 6'h38, 8'hFF, "w_pcifr"}, '{1'b0, 6'h38, 8'h00, "pcifr_no_set"}
    };
    reset = 1; drv = 0; dval = 0;
    bus.cs = 0; bus.we = 0; bus.oe = 0; bus.address = 0; bus.ack = 0;
    ext_en = 16'hFF00; ext_val = 16'h0000;
    step(); step();
    reset = 0;
    chk("rst_pins0", {8'h00, pins[7:0]}, 16'h00FF);
    chk("rst_irq", {15'd0, bus.irq}, 16'd0);
    chk("rst_vector", {6'd0, bus.vector}, 16'h0010);
    chk("bus_idle_z", {8'h00, data}, 16'h00FF);
    for (int i = 0; i < 18; i++)
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].dat);
      else rd(tbl[i].name, tbl[i].addr, tbl[i].dat);
    chk("pins_drive", {8'h00, pins[7:0]}, 16'h00F5);
    rd("pin0_readback", 6'h00, 8'hF5);
    bus.cs = 1; bus.we = 0; bus.oe = 1; bus.address = 6'h03;
    step();
    chk("pin1_init", {8'h00, data}, 16'h0000);
    ext_val[15:8] = 8'h3C;
    step();
    chk("pin1_sync1", {8'h00, data}, 16'h0000);
    step();
    chk("pin1_sync2", {8'h00, data}, 16'h003C);
    bus.cs = 0; bus.oe = 0;
    wr(6'h03, 8'hFF);
    rd("pin1_write_ignored", 6'h03, 8'h3C);
`ifdef PIN_TOGGLE_EN
    wr(6'h00, 8'h0F);
    rd("port0_toggle", 6'h02, 8'hAA);
    wr(6'h02, 8'hA5);
`else
    wr(6'h00, 8'h0F);
    rd("port0_no_toggle", 6'h02, 8'hA5);
`endif
    step(); step(); step();
    wr(6'h30, 8'h01); wr(6'h39, 8'h01); wr(6'h3F, 8'h80);
    chk("irq_quiet", {15'd0, bus.irq}, 16'd0);
    wr(6'h02, 8'hA4);
    step();
    chk("irq_early", {15'd0, bus.irq}, 16'd0);
    step();
    chk("irq_set", {15'd0, bus.irq}, 16'd1);
    chk("vector_p0", {6'd0, bus.vector}, 16'h0010);
    rd("pcifr_p0", 6'h38, 8'h01);
    bus.ack = 1; step(); bus.ack = 0;
    chk("irq_after_ack", {15'd0, bus.irq}, 16'd0);
    rd("pcifr_after_ack", 6'h38, 8'h00);
    wr(6'h31, 8'hFF); wr(6'h39, 8'h03);
    ext_val[15:8] = 8'hC3;
    wr(6'h02, 8'hA5);
    step(); step();
    rd("pcifr_both", 6'h38, 8'h03);
    chk("vector_prio", {6'd0, bus.vector}, 16'h0010);
    bus.ack = 1; step(); bus.ack = 0;
    chk("vector_p1", {6'd0, bus.vector}, 16'h0011);
    chk("irq_p1", {15'd0, bus.irq}, 16'd1);
    bus.ack = 1; step(); bus.ack = 0;
    chk("irq_all_acked", {15'd0, bus.irq}, 16'd0);
    chk("vector_idle", {6'd0, bus.vector}, 16'h0010);
    wr(6'h3F, 8'h00);
    ext_val[15:8] = 8'h3C;
    wr(6'h02, 8'hA4);
    step(); step();
    rd("pcifr_both2", 6'h38, 8'h03);
    chk("irq_sreg_off", {15'd0, bus.irq}, 16'd0);
    wr(6'h38, 8'h02);
    rd("w1c_bit1", 6'h38, 8'h01);
    ext_val[15:8] = 8'hC3;
    step(); step();
    rd("pcifr_both3", 6'h38, 8'h03);
    bus.cs = 1; bus.we = 1; bus.address = 6'h38; dval = 8'h02; drv = 1; bus.ack = 1;
    step();
    bus.cs = 0; bus.we = 0; drv = 0; bus.ack = 0;
    rd("ack_and_w1c", 6'h38, 8'h00);
    wr(6'h02, 8'hA5);
    step();
    wr(6'h38, 8'h01);
    rd("set_beats_w1c", 6'h38, 8'h01);
    wr(6'h3F, 8'h80);
    chk("irq_pre_reset", {15'd0, bus.irq}, 16'd1);
    bus.cs = 1; bus.we = 1; bus.address = 6'h01; dval = 8'hFF; drv = 1; reset = 1;
    step();
    bus.cs = 0; bus.we = 0; drv = 0;
    chk("reset_pins_z", {8'h00, pins[7:0]}, 16'h00FF);
    chk("reset_irq", {15'd0, bus.irq}, 16'd0);
    reset = 0;
    rd("reset_ddr0", 6'h01, 8'h00);
    rd("reset_port0", 6'h02, 8'h00);
    rd("reset_spl", 6'h3D, 8'hBF);
    rd("reset_pcmsk0", 6'h30, 8'h00);
    rd("reset_pcifr", 6'h38, 8'h00);
    rd("reset_sreg", 6'h3F, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
